cfg_reg_bank: RTL and testbench

Parametrised configuration register bank with masked writes, per-address read-only protection, per-register reset values and exported-register change notification. It is the next generation of the system's register file: it sits between the command/control FSM (the single read/write master) and the configuration consumers (ALU, UART, clock dividers). It exports its low registers as a flat bus, plus a one-cycle update strobe per exported register.

---
 rtl/cfg_reg_bank.sv | 64 ++++++
 tb/tb_cfg_reg_bank.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/cfg_reg_bank.sv
// cfg_reg_bank: config registers with masked writes, read-only protection, per-register reset values and update strobes
module cfg_reg_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int NUM_OUT = 4,
  parameter logic [DEPTH*WIDTH-1:0] RST_VALS = (DEPTH*WIDTH)'(32'h0821_0000),
  parameter logic [DEPTH-1:0] RO_MASK = '0,
  localparam int AW = (DEPTH > 2) ? $clog2(DEPTH) : 1
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WrEn,
  input  logic                     RdEn,
  input  logic [AW-1:0]            Address,
  input  logic [WIDTH-1:0]         WrData,
  input  logic [WIDTH-1:0]         WrMask,
  output logic [WIDTH-1:0]         RdData,
  output logic                     RdData_VLD,
  output logic                     Err,
  output logic [NUM_OUT*WIDTH-1:0] RegOut,
  output logic [NUM_OUT-1:0]       RegUpd
);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [WIDTH-1:0] rd_q, rd_d, cur, wr_val;
  logic [NUM_OUT-1:0] upd_q, upd_d;
  logic vld_q, err_q, err_d, in_rng, wr_ok, rd_ok;
  always_comb begin
    in_rng = 32'(Address) < DEPTH;
    cur = in_rng ? mem_q[Address] : '0;
    wr_val = (cur & ~WrMask) | (WrData & WrMask);
    rd_ok = RdEn && !WrEn;
    wr_ok = WrEn && !RdEn && in_rng && !RO_MASK[Address];
    err_d = (WrEn && RdEn) || (WrEn && !RdEn && !wr_ok) || (rd_ok && !in_rng);
    rd_d = rd_ok ? cur : rd_q;
  end
  for (genvar k = 0; k < DEPTH; k++) begin : g_reg
    assign mem_d[k] = (wr_ok && Address == AW'(k)) ? wr_val : mem_q[k];
    always_ff @(posedge CLK or negedge RST)
      if (!RST) mem_q[k] <= RST_VALS[k*WIDTH +: WIDTH];
      else mem_q[k] <= mem_d[k];
  end
  // a strobe fires only when the stored value actually changes
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_out
    assign RegOut[k*WIDTH +: WIDTH] = mem_q[k];
    assign upd_d[k] = mem_d[k] != mem_q[k];
  end
  always_ff @(posedge CLK or negedge RST)
    if (!RST) begin
      rd_q <= '0;
      vld_q <= 1'b0;
      err_q <= 1'b0;
      upd_q <= '0;
    end else begin
      rd_q <= rd_d;
      vld_q <= rd_ok;
      err_q <= err_d;
      upd_q <= upd_d;
    end
  assign RdData = rd_q;
  assign RdData_VLD = vld_q;
  assign Err = err_q;
  assign RegUpd = upd_q;
endmodule

// File: tb/tb_cfg_reg_bank.sv
// tb_cfg_reg_bank: directed vector table, reset corner cases and randomized traffic against a reference model
module tb_cfg_reg_bank;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic WrEn = 1'b0, RdEn = 1'b0;
  logic [3:0] Address = '0;
  logic [7:0] WrData = '0, WrMask = '0;
  logic [7:0] RdData;
  logic RdData_VLD, Err;
  logic [31:0] RegOut;
  logic [3:0] RegUpd;

  cfg_reg_bank #(.DEPTH(10), .RO_MASK(10'b00_0000_1000)) dut (
    .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address),
    .WrData(WrData), .WrMask(WrMask), .RdData(RdData), .RdData_VLD(RdData_VLD),
    .Err(Err), .RegOut(RegOut), .RegUpd(RegUpd)
  );

  always #5 CLK = ~CLK;

  int total = 0, bad = 0;
  logic [7:0] m [10];
  logic [7:0] e_rd;
  logic e_vld, e_err;
  logic [3:0] e_upd;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m[i]) m[i] = 8'h00;
    m[2] = 8'h21;
    m[3] = 8'h08;
    e_rd = '0; e_vld = 1'b0; e_err = 1'b0; e_upd = '0;
  endtask

  task automatic model_step(input logic we, input logic re, input logic [3:0] a,
                            input logic [7:0] wd, input logic [7:0] wm);
    logic [7:0] nv;
    e_vld = 1'b0; e_err = 1'b0; e_upd = '0;
    if (we && re) e_err = 1'b1;
    else if (we) begin
      if (a >= 10 || a == 3) e_err = 1'b1;
      else begin
        nv = (m[a] & ~wm) | (wd & wm);
        if (a < 4 && nv != m[a]) e_upd[a] = 1'b1;
        m[a] = nv;
      end
    end else if (re) begin
      e_vld = 1'b1;
      e_err = a >= 10;
      e_rd = (a < 10) ? m[a] : 8'h00;
    end
  endtask

  task automatic check_model(input string t);
    chk({t, "_rd"}, 32'(RdData), 32'(e_rd));
    chk({t, "_vld"}, 32'(RdData_VLD), 32'(e_vld));
    chk({t, "_err"}, 32'(Err), 32'(e_err));
    chk({t, "_upd"}, 32'(RegUpd), 32'(e_upd));
    chk({t, "_regout"}, RegOut, {m[3], m[2], m[1], m[0]});
  endtask

  task automatic do_req(input logic we, input logic re, input logic [3:0] a,
                        input logic [7:0] wd, input logic [7:0] wm);
    WrEn = we; RdEn = re; Address = a; WrData = wd; WrMask = wm;
    @(posedge CLK);
    #1;
    model_step(we, re, a, wd, wm);
    WrEn = 1'b0; RdEn = 1'b0;
  endtask

  typedef struct packed {
    logic we, re;
    logic [3:0] a;
    logic [7:0] wd, wm, rd;
    logic vld, err;
    logic [3:0] upd;
  } vec_t;
  vec_t tv [15];

  initial begin
    tv[0]  = '{1'b0, 1'b1, 4'd2,  8'h00, 8'h00, 8'h21, 1'b1, 1'b0, 4'b0000};
    tv[1]  = '{1'b1, 1'b0, 4'd1,  8'hFF, 8'h0F, 8'h21, 1'b0, 1'b0, 4'b0010};
    tv[2]  = '{1'b1, 1'b0, 4'd1,  8'hFF, 8'h0F, 8'h21, 1'b0, 1'b0, 4'b0000};
    tv[3]  = '{1'b0, 1'b1, 4'd1,  8'h00, 8'h00, 8'h0F, 1'b1, 1'b0, 4'b0000};
    tv[4]  = '{1'b1, 1'b0, 4'd3,  8'hAA, 8'hFF, 8'h0F, 1'b0, 1'b1, 4'b0000};
    tv[5]  = '{1'b0, 1'b1, 4'd3,  8'h00, 8'h00, 8'h08, 1'b1, 1'b0, 4'b0000};
    tv[6]  = '{1'b1, 1'b1, 4'd0,  8'h55, 8'hFF, 8'h08, 1'b0, 1'b1, 4'b0000};
    tv[7]  = '{1'b0, 1'b1, 4'd0,  8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 4'b0000};
    tv[8]  = '{1'b1, 1'b0, 4'd12, 8'h77, 8'hFF, 8'h00, 1'b0, 1'b1, 4'b0000};
    tv[9]  = '{1'b0, 1'b1, 4'd12, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 4'b0000};
    tv[10] = '{1'b1, 1'b0, 4'd9,  8'hA5, 8'hFF, 8'h00, 1'b0, 1'b0, 4'b0000};
    tv[11] = '{1'b0, 1'b1, 4'd9,  8'h00, 8'h00, 8'hA5, 1'b1, 1'b0, 4'b0000};
    tv[12] = '{1'b1, 1'b0, 4'd0,  8'h3C, 8'hF0, 8'hA5, 1'b0, 1'b0, 4'b0001};
    tv[13] = '{1'b0, 1'b1, 4'd0,  8'h00, 8'h00, 8'h30, 1'b1, 1'b0, 4'b0000};
    tv[14] = '{1'b0, 1'b0, 4'd0,  8'h00, 8'h00, 8'h30, 1'b0, 1'b0, 4'b0000};
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_regout", RegOut, 32'h0821_0000);
    chk("rst_rd", 32'(RdData), 32'h0);
    chk("rst_vld", 32'(RdData_VLD), 32'h0);
    chk("rst_err", 32'(Err), 32'h0);
    chk("rst_upd", 32'(RegUpd), 32'h0);
    #2 RST = 1'b1;
    for (int i = 0; i < 15; i++) begin
      do_req(tv[i].we, tv[i].re, tv[i].a, tv[i].wd, tv[i].wm);
      chk($sformatf("tv%0d_rd", i), 32'(RdData), 32'(tv[i].rd));
      chk($sformatf("tv%0d_vld", i), 32'(RdData_VLD), 32'(tv[i].vld));
      chk($sformatf("tv%0d_err", i), 32'(Err), 32'(tv[i].err));
      chk($sformatf("tv%0d_upd", i), 32'(RegUpd), 32'(tv[i].upd));
      chk($sformatf("tv%0d_regout", i), RegOut, {m[3], m[2], m[1], m[0]});
    end
    chk("ro_slice3", 32'(RegOut[31:24]), 32'h08);
    for (int i = 0; i < 400; i++) begin
      logic [7:0] wm;
      wm = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
             8'($urandom), wm);
      check_model("rnd");
    end
    do_req(1'b1, 1'b0, 4'd1, 8'hC3, 8'hFF);
    check_model("pre_wr");
    do_req(1'b0, 1'b1, 4'd1, 8'h00, 8'h00);
    check_model("b2b_rd0");
    do_req(1'b0, 1'b1, 4'd2, 8'h00, 8'h00);
    check_model("b2b_rd1");
    #2 RST = 1'b0;
    #1;
    model_reset();
    chk("mid_rst_vld", 32'(RdData_VLD), 32'h0);
    chk("mid_rst_rd", 32'(RdData), 32'h0);
    chk("mid_rst_mem1", 32'(RegOut[15:8]), 32'h0);
    chk("mid_rst_regout", RegOut, 32'h0821_0000);
    @(posedge CLK);
    #1;
    check_model("held_rst");
    #2 RST = 1'b1;
    do_req(1'b0, 1'b1, 4'd1, 8'h00, 8'h00);
    check_model("post_rst_rd");
    chk("post_rst_vld", 32'(RdData_VLD), 32'h1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
